score_tracker: RTL and testbench

Holds the persistent score records for the game: one personal-best score per internal player ID, plus the global-best score and its holder. It sits directly downstream of the post-game score checker. On a score request it compares the submitted score against both records, updates them, and returns a valid pulse with personalwin/globalwin verdicts. It also exports the current global best for display logic.

---
 rtl/score_tracker_pkg.sv | 16 +
 rtl/score_tracker_regfile.sv | 56 +++++
 rtl/score_tracker.sv | 146 ++++++++++++++
 tb/tb_score_tracker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_tracker_pkg.sv
// Shared definitions for the score checker / score tracker pair:
// FSM state encodings and default record widths.
package score_tracker_pkg;

   localparam int DEF_NUM_PLAYERS = 8;
   localparam int DEF_ID_W        = 3;
   localparam int DEF_SCORE_W     = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      COMPARE = 2'd2,
      UPDATE  = 2'd3
   } state_e;

endpackage : score_tracker_pkg

// File: rtl/score_tracker_regfile.sv
// Personal-best register file: one registered read port, one write port,
// a synchronous clear-all and an asynchronous active-low reset.
module score_regfile
   import score_tracker_pkg::*;
#(
   parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
   parameter int ID_W        = DEF_ID_W,
   parameter int SCORE_W     = DEF_SCORE_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               rdEn_i,
   input  logic [ID_W-1:0]    rdAddr_i,
   output logic [SCORE_W-1:0] rdData_o,
   input  logic               wrEn_i,
   input  logic [ID_W-1:0]    wrAddr_i,
   input  logic [SCORE_W-1:0] wrData_i
);

   localparam logic [ID_W:0] LIMIT = (ID_W + 1)'(NUM_PLAYERS);

   logic [SCORE_W-1:0] mem_q [NUM_PLAYERS];
   logic [SCORE_W-1:0] rdData_q;
   logic               rdInRange;
   logic               wrInRange;

   // Addresses beyond the populated slots read as zero and drop writes.
   assign rdInRange = ({1'b0, rdAddr_i} < LIMIT);
   assign wrInRange = ({1'b0, wrAddr_i} < LIMIT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear_i) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wrEn_i && wrInRange) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdData_q <= '0;
      end else if (rdEn_i) begin
         rdData_q <= rdInRange ? mem_q[rdAddr_i] : '0;
      end
   end

   assign rdData_o = rdData_q;

endmodule : score_regfile

// File: rtl/score_tracker.sv
// Persistent score records: per-player personal bests plus the global best,
// updated from accepted score requests with personal/global win verdicts.
module score_tracker
   import score_tracker_pkg::*;
#(
   parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
   parameter int ID_W        = DEF_ID_W,
   parameter int SCORE_W     = DEF_SCORE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               score_req,
   input  logic [SCORE_W-1:0] score_in,
   input  logic [ID_W-1:0]    intPlayID_in,
   input  logic               isGuest_in,
   input  logic               clear_scores,
   output logic               valid,
   output logic               personalwin,
   output logic               globalwin,
   output logic               busy,
   output logic [SCORE_W-1:0] global_best,
   output logic [ID_W-1:0]    global_id,
   output logic               global_guest
);

   state_e             state_q, state_d;

   logic               accept, doClear, doLookup, doCompare, doUpdate;

   logic [SCORE_W-1:0] score_q;
   logic [ID_W-1:0]    id_q;
   logic               guest_q;
   logic               pw_q, gw_q;
   logic               personalWin_q, globalWin_q, valid_q;
   logic [SCORE_W-1:0] globalBest_q;
   logic [ID_W-1:0]    globalId_q;
   logic               globalGuest_q;
   logic [SCORE_W-1:0] pbest;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (score_req) state_d = LOOKUP;
         LOOKUP:  state_d = COMPARE;
         COMPARE: state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A request in IDLE wins over a simultaneous clear.
   always_comb begin
      accept    = 1'b0;
      doClear   = 1'b0;
      doLookup  = 1'b0;
      doCompare = 1'b0;
      doUpdate  = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy    = 1'b0;
            accept  = score_req;
            doClear = !score_req && clear_scores;
         end
         LOOKUP:  doLookup  = 1'b1;
         COMPARE: doCompare = 1'b1;
         UPDATE:  doUpdate  = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         score_q       <= '0;
         id_q          <= '0;
         guest_q       <= 1'b0;
         pw_q          <= 1'b0;
         gw_q          <= 1'b0;
         personalWin_q <= 1'b0;
         globalWin_q   <= 1'b0;
         valid_q       <= 1'b0;
         globalBest_q  <= '0;
         globalId_q    <= '0;
         globalGuest_q <= 1'b0;
      end else begin
         valid_q <= doUpdate;
         if (accept) begin
            score_q       <= score_in;
            id_q          <= intPlayID_in;
            guest_q       <= isGuest_in;
            personalWin_q <= 1'b0;
            globalWin_q   <= 1'b0;
         end
         if (doCompare) begin
            pw_q <= !guest_q && (score_q > pbest);
            gw_q <= (score_q > globalBest_q);
         end
         if (doUpdate) begin
            personalWin_q <= pw_q;
            globalWin_q   <= gw_q;
            if (gw_q) begin
               globalBest_q  <= score_q;
               globalId_q    <= id_q;
               globalGuest_q <= guest_q;
            end
         end
         if (doClear) begin
            globalBest_q  <= '0;
            globalId_q    <= '0;
            globalGuest_q <= 1'b0;
         end
      end
   end

   score_regfile #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .ID_W        (ID_W),
      .SCORE_W     (SCORE_W)
   ) u_regfile (
      .clk_i    (clk),
      .rst_ni   (rst),
      .clear_i  (doClear),
      .rdEn_i   (doLookup),
      .rdAddr_i (id_q),
      .rdData_o (pbest),
      .wrEn_i   (doUpdate && pw_q),
      .wrAddr_i (id_q),
      .wrData_i (score_q)
   );

   assign valid        = valid_q;
   assign personalwin  = personalWin_q;
   assign globalwin    = globalWin_q;
   assign global_best  = globalBest_q;
   assign global_id    = globalId_q;
   assign global_guest = globalGuest_q;

endmodule : score_tracker

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a reference model predicts each verdict
// into a queue, popped and compared when the valid pulse appears.
module tb_score_tracker;

   localparam int NP = 8;
   localparam int IW = 3;
   localparam int SW = 7;

   typedef struct packed {
      logic          pw;
      logic          gw;
      logic [SW-1:0] best;
      logic [IW-1:0] id;
      logic          guest;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          score_req;
   logic [SW-1:0] score_in;
   logic [IW-1:0] intPlayID_in;
   logic          isGuest_in;
   logic          clear_scores;
   logic          valid;
   logic          personalwin;
   logic          globalwin;
   logic          busy;
   logic [SW-1:0] global_best;
   logic [IW-1:0] global_id;
   logic          global_guest;

   exp_t          sbQ[$];
   int            checks = 0;
   int            errors = 0;

   logic [SW-1:0] pbModel [NP];
   logic [SW-1:0] gBest;
   logic [IW-1:0] gId;
   logic          gGuest;

   score_tracker #(.NUM_PLAYERS(NP), .ID_W(IW), .SCORE_W(SW)) dut (
      .clk          (clk),
      .rst          (rst),
      .score_req    (score_req),
      .score_in     (score_in),
      .intPlayID_in (intPlayID_in),
      .isGuest_in   (isGuest_in),
      .clear_scores (clear_scores),
      .valid        (valid),
      .personalwin  (personalwin),
      .globalwin    (globalwin),
      .busy         (busy),
      .global_best  (global_best),
      .global_id    (global_id),
      .global_guest (global_guest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < NP; i++) pbModel[i] = '0;
      gBest  = '0;
      gId    = '0;
      gGuest = 1'b0;
   endtask

   // Drives one request pulse at a falling edge and queues the predicted verdict.
   task automatic applyStimulus(input int id, input int score, input logic guest);
      exp_t e;
      @(negedge clk);
      score_req    = 1'b1;
      score_in     = SW'(score);
      intPlayID_in = IW'(id);
      isGuest_in   = guest;
      e.pw = !guest && (id < NP) && (SW'(score) > pbModel[id % NP]);
      e.gw = SW'(score) > gBest;
      if (e.pw) pbModel[id % NP] = SW'(score);
      if (e.gw) begin
         gBest  = SW'(score);
         gId    = IW'(id);
         gGuest = guest;
      end
      e.best  = gBest;
      e.id    = gId;
      e.guest = gGuest;
      sbQ.push_back(e);
   endtask

   // Waits (bounded) for valid, checking latency, busy span, verdicts and hold.
   task automatic checkOutput(input string tag, input logic dupReq);
      int   lat;
      int   busyCnt;
      exp_t e;
      @(negedge clk);
      lat = 1;
      busyCnt = busy ? 1 : 0;
      if (dupReq) begin
         score_in     = 7'd127;
         intPlayID_in = 3'd1;
         isGuest_in   = 1'b0;
      end else begin
         score_req = 1'b0;
      end
      while (!valid && lat < 20) begin
         @(negedge clk);
         score_req = 1'b0;
         lat++;
         if (busy) busyCnt++;
      end
      checkValue({tag, " latency"}, lat, 4);
      checkValue({tag, " busy cycles"}, busyCnt, 3);
      if (sbQ.size() == 0) begin
         checkValue({tag, " scoreboard entry"}, 0, 1);
         return;
      end
      e = sbQ.pop_front();
      checkValue({tag, " personalwin"}, personalwin, e.pw);
      checkValue({tag, " globalwin"}, globalwin, e.gw);
      checkValue({tag, " global_best"}, global_best, e.best);
      checkValue({tag, " global_id"}, global_id, e.id);
      checkValue({tag, " global_guest"}, global_guest, e.guest);
      @(negedge clk);
      checkValue({tag, " valid single"}, valid, 0);
      @(negedge clk);
      checkValue({tag, " pw held"}, personalwin, e.pw);
      checkValue({tag, " gw held"}, globalwin, e.gw);
   endtask

   initial begin
      int sawValid;
      rst          = 1'b0;
      score_req    = 1'b0;
      score_in     = '0;
      intPlayID_in = '0;
      isGuest_in   = 1'b0;
      clear_scores = 1'b0;
      clearModel();

      repeat (3) @(negedge clk);
      checkValue("reset valid", valid, 0);
      checkValue("reset busy", busy, 0);
      checkValue("reset personalwin", personalwin, 0);
      checkValue("reset globalwin", globalwin, 0);
      checkValue("reset global_best", global_best, 0);
      checkValue("reset global_id", global_id, 0);
      checkValue("reset global_guest", global_guest, 0);
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(2, 40, 1'b0);
      checkOutput("first", 1'b0);
      applyStimulus(3, 40, 1'b0);
      checkOutput("tie", 1'b0);
      applyStimulus(2, 25, 1'b0);
      checkOutput("lower", 1'b0);
      applyStimulus(2, 41, 1'b0);
      checkOutput("raise", 1'b0);
      applyStimulus(5, 100, 1'b1);
      checkOutput("guest", 1'b0);
      applyStimulus(5, 1, 1'b0);
      checkOutput("after guest", 1'b0);

      applyStimulus(6, 10, 1'b0);
      checkOutput("ignored dup", 1'b1);
      sawValid = 0;
      repeat (6) begin
         @(negedge clk);
         if (valid) sawValid++;
      end
      checkValue("dup no extra valid", sawValid, 0);
      checkValue("dup global_best", global_best, 100);

      // Reset lands while the request sits in COMPARE.
      @(negedge clk);
      score_req    = 1'b1;
      score_in     = 7'd120;
      intPlayID_in = 3'd4;
      isGuest_in   = 1'b0;
      @(negedge clk);
      score_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      clearModel();
      sawValid = 0;
      repeat (6) begin
         @(negedge clk);
         if (valid) sawValid++;
      end
      checkValue("abort no valid", sawValid, 0);
      checkValue("abort global_best", global_best, 0);
      checkValue("abort global_id", global_id, 0);
      checkValue("abort global_guest", global_guest, 0);
      checkValue("abort busy", busy, 0);

      applyStimulus(3, 5, 1'b0);
      checkOutput("post reset", 1'b0);
      applyStimulus(2, 50, 1'b0);
      checkOutput("pre clear", 1'b0);

      @(negedge clk);
      clear_scores = 1'b1;
      @(negedge clk);
      clear_scores = 1'b0;
      clearModel();
      checkValue("clear global_best", global_best, 0);
      checkValue("clear global_id", global_id, 0);

      applyStimulus(2, 1, 1'b0);
      checkOutput("post clear", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_score_tracker
